// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |divisor| > |dividend|.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            sel_rem_q, sel_rem_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            ovalid_q, ovalid_d;

    logic            signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            ovf;
    logic [XLEN:0]   rem_sh, trial;
    logic            take;
    logic [XLEN-1:0] rem_nx, quo_nx, rem_fix, quo_fix;

    // funct3[0]=1 selects the unsigned variants; funct3[1]=1 selects remainder
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[XLEN-1];
    assign b_neg     = signed_op & b[XLEN-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
    assign ovf       = signed_op && (a == MIN_NEG) && (b == '1);

    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign trial   = rem_sh - {1'b0, dvs_q};
    assign take    = ~trial[XLEN];
    assign rem_nx  = take ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], take};
    assign quo_fix = qneg_q ? (~quo_nx + 1'b1) : quo_nx;
    assign rem_fix = rneg_q ? (~rem_nx + 1'b1) : rem_nx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        res_d     = res_q;
        ovalid_d  = ovalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    sel_rem_d = op[1];
                    if (b == '0) begin
                        res_d    = op[1] ? a : '1;
                        state_d  = S_DONE;
                        ovalid_d = 1'b1;
                    end else if (ovf) begin
                        res_d    = op[1] ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                        ovalid_d = 1'b1;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (b_mag > a_mag) begin
                        res_d    = op[1] ? a : '0;
                        state_d  = S_DONE;
                        ovalid_d = 1'b1;
                    end
`endif
                    else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        qneg_d  = signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                        rneg_d  = signed_op & a[XLEN-1];
                        cnt_d   = CW'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    res_d    = sel_rem_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                    ovalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d  = S_IDLE;
                    ovalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ovalid_d = 1'b0;
            end
        endcase

        // flush wins over everything and leaves the last result in place
        if (flush) begin
            state_d  = S_IDLE;
            ovalid_d = 1'b0;
            cnt_d    = '0;
            res_d    = res_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            res_q     <= '0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            res_q     <= res_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ovalid_q;
    assign res       = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against an arithmetic model.
module tb_div_unit;

    localparam int unsigned W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with wide signed arithmetic
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] o);
        longint sx, sy, q, r;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = {32'h0, x};
            sy = {32'h0, y};
        end
        q = sx / sy;
        r = sx % sy;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
        longint mx, my;
        if (y == 0) return 1;
        if (!o[0] && x == MINV && y == 32'hFFFF_FFFF) return 1;
        mx = o[0] ? longint'({32'h0, x}) : longint'($signed(x));
        my = o[0] ? longint'({32'h0, y}) : longint'($signed(y));
        if (mx < 0) mx = -mx;
        if (my < 0) my = -my;
`ifdef DIV_EARLY_OUT_EN
        if (my > mx) return 1;
`endif
        return 33;
    endfunction

    // Called #1 after a rising edge with the unit idle; returns #1 after the acceptance edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
        in_valid = 1'b1;
        a = x;
        b = y;
        op = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [W-1:0] exp, input int lat, input int stall);
        int n;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " res"}, res, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold res"}, res, exp);
            chk({tag, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [1:0] o, input int stall);
        issue(x, y, o);
        collect(tag, ref_res(x, y, o), ref_lat(x, y, o), stall);
    endtask

    initial begin
        int n, seen, sel;
        logic [W-1:0] rx, ry;
        logic [1:0]   ro;

        #3;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset res", res, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run("divu 100/7", 32'd100, 32'd7, OP_DIVU, 0);
        run("remu 100/7", 32'd100, 32'd7, OP_REMU, 0);
        run("div -7/2", 32'hFFFF_FFF9, 32'd2, OP_DIV, 0);
        run("rem -7/2", 32'hFFFF_FFF9, 32'd2, OP_REM, 0);
        run("div 5/0", 32'd5, 32'd0, OP_DIV, 0);
        run("rem 5/0", 32'd5, 32'd0, OP_REM, 0);
        run("divu 0/0", 32'd0, 32'd0, OP_DIVU, 0);
        run("div ovf", MINV, 32'hFFFF_FFFF, OP_DIV, 0);
        run("rem ovf", MINV, 32'hFFFF_FFFF, OP_REM, 0);
        run("divu 3/10", 32'd3, 32'd10, OP_DIVU, 0);
        run("rem 7/-3", 32'd7, 32'hFFFF_FFFD, OP_REM, 0);
        chk("div 100/7 model", ref_res(32'd100, 32'd7, OP_DIVU), 32'd14);

        // Backpressure with a pending request that must wait for the handoff
        issue(32'd1000, 32'd10, OP_DIVU);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp latency", 32'(n), 32'd33);
        chk("bp res", res, 32'd100);
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd3;
        op = OP_DIVU;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold res", res, 32'd100);
            chk("bp hold valid", {31'b0, out_valid}, 32'd1);
            chk("bp hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp handoff valid", {31'b0, out_valid}, 32'd0);
        chk("bp handoff not accepted", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("reissue accepted", {31'b0, in_ready}, 32'd0);
        collect("reissue 9/3", 32'd3, 33, 0);

        // Flush mid-computation
        issue(32'hFFFF_FFFF, 32'd3, OP_DIVU);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("flush no out_valid", 32'(seen), 32'd0);
        run("post-flush 9/3", 32'd9, 32'd3, OP_DIVU, 0);

        // Flush together with in_valid in IDLE: request is dropped
        in_valid = 1'b1;
        flush = 1'b1;
        a = 32'd5;
        b = 32'd0;
        op = OP_DIV;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush+in_valid in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush+in_valid out_valid", {31'b0, out_valid}, 32'd0);

        // Flush together with out_ready in DONE: back to IDLE, res untouched
        issue(32'd5, 32'd0, OP_DIV);
        chk("done before flush", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush done out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush done in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush done res kept", res, 32'hFFFF_FFFF);

        // Asynchronous reset mid-computation
        issue(32'd100, 32'd7, OP_DIVU);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("async rst res", res, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run("post-reset remu", 32'd100, 32'd7, OP_REMU, 0);

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 7);
            rx = $urandom;
            ry = $urandom;
            ro = 2'($urandom_range(0, 3));
            case (sel)
                0: ry = '0;
                1: begin rx = MINV; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 16));
                3: ry = ry >> $urandom_range(0, 31);
                4: ry = -32'($urandom_range(1, 20));
                5: rx = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run($sformatf("rand a=%h b=%h op=%0d", rx, ry, ro), rx, ry, ro, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
